// File: rtl/mp_bus_arbiter_if.sv
// Core-bus and shared-memory signal bundle for mp_bus_arbiter.
// Latency: none, wires only.
// Backpressure: nWait (core side) and Mem_ack (memory side) are carried here.
interface mp_bus_arbiter_if #(
  parameter int NCORES = 4,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 54
);
  // core channel side
  logic [NCORES-1:0]        nALE;
  logic [NCORES-1:0]        nME;
  logic [NCORES-1:0]        RnW;
  logic [NCORES-1:0]        nOE;
  logic [NCORES*DATA_W-1:0] Bus_in;
  logic [NCORES*DATA_W-1:0] Bus_out;
  logic [NCORES-1:0]        Bus_oe;
  logic [NCORES-1:0]        nWait;
  logic [NCORES-1:0]        Err;
  // shared memory port
  logic                     Mem_req;
  logic                     Mem_we;
  logic [ADDR_W-1:0]        Mem_addr;
  logic [DATA_W-1:0]        Mem_wdata;
  logic [DATA_W-1:0]        Mem_rdata;
  logic                     Mem_ack;

  modport slave (
    input  nALE, nME, RnW, nOE, Bus_in, Mem_rdata, Mem_ack,
    output Bus_out, Bus_oe, nWait, Err, Mem_req, Mem_we, Mem_addr, Mem_wdata
  );

  modport master (
    output nALE, nME, RnW, nOE, Bus_in, Mem_rdata, Mem_ack,
    input  Bus_out, Bus_oe, nWait, Err, Mem_req, Mem_we, Mem_addr, Mem_wdata
  );
endinterface

// File: rtl/mp_bus_arbiter.sv
// Latches NCORES multiplexed core buses and round-robins their requests onto one memory port.
// Latency: strobe sampled in ADDR -> Mem_req two edges later; Bus_oe one edge after Mem_ack.
// Backpressure: nWait low while a channel is PEND/BUSY; Mem_req/payload held until Mem_ack.
module mp_bus_arbiter #(
  parameter int NCORES = 4,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 54
) (
  input  logic                Clock,
  input  logic                nReset,
  mp_bus_arbiter_if.slave     bus
);

  localparam int PTR_W = (NCORES > 1) ? $clog2(NCORES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_PEND,
    S_BUSY,
    S_DONE
  } state_t;

  state_t              state_q   [NCORES];
  state_t              state_d   [NCORES];
  logic [ADDR_W-1:0]   addr_q    [NCORES];
  logic [DATA_W-1:0]   wdata_q   [NCORES];
  logic [DATA_W-1:0]   rdata_q   [NCORES];
  logic [DATA_W-1:0]   bus_in_w  [NCORES];
  logic [NCORES-1:0]   we_q;
  logic [NCORES-1:0]   err_q;
  logic [NCORES-1:0]   oe_q;
  logic [NCORES-1:0]   nwait_q;

  logic [NCORES-1:0]   lat_addr;
  logic [NCORES-1:0]   lat_wdata;
  logic [NCORES-1:0]   go_pend;
  logic [NCORES-1:0]   set_err;
  logic [NCORES-1:0]   cap_rdata;

  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [PTR_W-1:0]    ptr_q;

  logic                any_busy;
  logic                grant_vld;
  logic [PTR_W-1:0]    grant_idx;
  logic                ack_hit;
  logic [NCORES*DATA_W-1:0] bus_out_flat;

  // an ack only counts while a request is actually on the port
  assign ack_hit = mem_req_q & bus.Mem_ack;

  // split the flat core bus into per-channel words
  always_comb begin
    for (int i = 0; i < NCORES; i++) begin
      bus_in_w[i] = bus.Bus_in[i*DATA_W +: DATA_W];
    end
  end

  // one memory transaction in flight at a time
  always_comb begin
    any_busy = 1'b0;
    for (int i = 0; i < NCORES; i++) begin
      if (state_q[i] == S_BUSY) any_busy = 1'b1;
    end
  end

  // round-robin search from ptr upward; descending loop so the nearest PEND channel wins
  always_comb begin
    int c;
    c         = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = NCORES - 1; k >= 0; k--) begin
      c = (int'(ptr_q) + k) % NCORES;
      if (!any_busy && state_q[c] == S_PEND) begin
        grant_vld = 1'b1;
        grant_idx = PTR_W'(c);
      end
    end
  end

  // per-channel next state and datapath enables
  always_comb begin
    for (int i = 0; i < NCORES; i++) begin
      state_d[i]   = state_q[i];
      lat_addr[i]  = 1'b0;
      lat_wdata[i] = 1'b0;
      go_pend[i]   = 1'b0;
      set_err[i]   = 1'b0;
      cap_rdata[i] = 1'b0;
      case (state_q[i])
        S_IDLE: begin
          if (!bus.nALE[i]) begin
            lat_addr[i] = 1'b1;
            state_d[i]  = S_ADDR;
          end else if (!bus.nME[i]) begin
            set_err[i]  = 1'b1;
          end
        end
        S_ADDR: begin
          if (!bus.nALE[i]) begin
            lat_addr[i]  = 1'b1;
          end else if (!bus.nME[i] && !bus.RnW[i]) begin
            lat_wdata[i] = 1'b1;
            go_pend[i]   = 1'b1;
            state_d[i]   = S_PEND;
          end else if (!bus.nME[i] && bus.RnW[i] && !bus.nOE[i]) begin
            go_pend[i]   = 1'b1;
            state_d[i]   = S_PEND;
          end
        end
        S_PEND: begin
          if (!bus.nALE[i]) set_err[i] = 1'b1;
          if (grant_vld && grant_idx == PTR_W'(i)) state_d[i] = S_BUSY;
        end
        S_BUSY: begin
          if (!bus.nALE[i]) set_err[i] = 1'b1;
          if (ack_hit) begin
            cap_rdata[i] = ~we_q[i];
            state_d[i]   = we_q[i] ? S_IDLE : S_DONE;
          end
        end
        S_DONE: begin
          if (!bus.nALE[i]) begin
            lat_addr[i] = 1'b1;
            state_d[i]  = S_ADDR;
          end else if (bus.nME[i] || bus.nOE[i]) begin
            state_d[i]  = S_IDLE;
          end
        end
        default: state_d[i] = S_IDLE;
      endcase
    end
  end

  // per-channel state, latched address/data, sticky error and registered core outputs
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < NCORES; i++) begin
        state_q[i] <= S_IDLE;
        addr_q[i]  <= '0;
        wdata_q[i] <= '0;
        rdata_q[i] <= '0;
      end
      we_q    <= '0;
      err_q   <= '0;
      oe_q    <= '0;
      nwait_q <= '1;
    end else begin
      for (int i = 0; i < NCORES; i++) begin
        state_q[i] <= state_d[i];
        if (lat_addr[i])  addr_q[i]  <= bus_in_w[i][ADDR_W-1:0];
        if (lat_wdata[i]) wdata_q[i] <= bus_in_w[i];
        if (go_pend[i])   we_q[i]    <= ~bus.RnW[i];
        if (cap_rdata[i]) rdata_q[i] <= bus.Mem_rdata;
        if (set_err[i])   err_q[i]   <= 1'b1;
        oe_q[i]    <= (state_d[i] == S_DONE);
        nwait_q[i] <= !((state_d[i] == S_PEND) || (state_d[i] == S_BUSY));
      end
    end
  end

  // memory port: load payload on grant, hold until ack, advance the round-robin pointer
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ptr_q       <= '0;
    end else if (ack_hit) begin
      mem_req_q <= 1'b0;
    end else if (grant_vld) begin
      mem_req_q   <= 1'b1;
      mem_we_q    <= we_q[grant_idx];
      mem_addr_q  <= addr_q[grant_idx];
      mem_wdata_q <= wdata_q[grant_idx];
      ptr_q       <= (grant_idx == PTR_W'(NCORES - 1)) ? '0 : grant_idx + PTR_W'(1);
    end
  end

  // pack per-channel read data back onto the flat core bus
  always_comb begin
    bus_out_flat = '0;
    for (int i = 0; i < NCORES; i++) begin
      bus_out_flat[i*DATA_W +: DATA_W] = rdata_q[i];
    end
  end

  assign bus.Bus_out   = bus_out_flat;
  assign bus.Bus_oe    = oe_q;
  assign bus.nWait     = nwait_q;
  assign bus.Err       = err_q;
  assign bus.Mem_req   = mem_req_q;
  assign bus.Mem_we    = mem_we_q;
  assign bus.Mem_addr  = mem_addr_q;
  assign bus.Mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mp_bus_arbiter.sv
// Directed bench for mp_bus_arbiter: reset, read, write, contention, error, early release.
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled at the same point.
// Backpressure: memory acks are driven by hand at fixed cycles.
module tb_mp_bus_arbiter;

  localparam int NC = 4;
  localparam int DW = 64;
  localparam int AW = 54;

  logic Clock  = 1'b0;
  logic nReset = 1'b0;

  always #5 Clock = ~Clock;

  mp_bus_arbiter_if #(.NCORES(NC), .DATA_W(DW), .ADDR_W(AW)) bus_if ();

  mp_bus_arbiter #(.NCORES(NC), .DATA_W(DW), .ADDR_W(AW)) dut (
    .Clock  (Clock),
    .nReset (nReset),
    .bus    (bus_if)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic set_bus(input int ch, input logic [63:0] v);
    bus_if.Bus_in[ch*DW +: DW] = v;
  endtask

  function automatic logic [63:0] bout(input int ch);
    return bus_if.Bus_out[ch*DW +: DW];
  endfunction

  logic [63:0] exp_addr;
  logic [63:0] exp_rd;

  initial begin
    bus_if.nALE      = '1;
    bus_if.nME       = '1;
    bus_if.RnW       = '1;
    bus_if.nOE       = '1;
    bus_if.Bus_in    = '0;
    bus_if.Mem_ack   = 1'b0;
    bus_if.Mem_rdata = '0;
    tick();
    tick();

    // ---- reset state
    chk("rst_mem_req",  bus_if.Mem_req,  0);
    chk("rst_mem_we",   bus_if.Mem_we,   0);
    chk("rst_mem_addr", bus_if.Mem_addr, 0);
    chk("rst_bus_oe",   bus_if.Bus_oe,   0);
    chk("rst_nwait",    bus_if.nWait,    4'hF);
    chk("rst_err",      bus_if.Err,      0);
    chk("rst_bus_out0", bout(0),         0);
    nReset = 1'b1;
    tick();

    // ---- single read on ch0
    bus_if.nALE[0] = 1'b0;
    set_bus(0, 64'h0000_0000_0000_0123);
    tick();                                   // ch0 ADDR
    bus_if.nALE[0] = 1'b1;
    bus_if.nME[0]  = 1'b0;
    bus_if.nOE[0]  = 1'b0;
    bus_if.RnW[0]  = 1'b1;
    tick();                                   // strobe sampled: PEND
    chk("rd_nwait_pend", bus_if.nWait[0], 0);
    chk("rd_req_pend",   bus_if.Mem_req,  0);
    tick();                                   // grant
    chk("rd_req",        bus_if.Mem_req,  1);
    chk("rd_addr",       bus_if.Mem_addr, 64'h123);
    chk("rd_we",         bus_if.Mem_we,   0);
    chk("rd_nwait_busy", bus_if.nWait[0], 0);
    bus_if.Mem_ack   = 1'b1;
    bus_if.Mem_rdata = 64'hDEAD_BEEF_0000_0001;
    tick();                                   // ack edge: DONE
    bus_if.Mem_ack   = 1'b0;
    chk("rd_req_drop",   bus_if.Mem_req,  0);
    chk("rd_nwait_rel",  bus_if.nWait[0], 1);
    chk("rd_oe",         bus_if.Bus_oe,   4'b0001);
    chk("rd_data",       bout(0),         64'hDEAD_BEEF_0000_0001);
    tick();
    chk("rd_oe_hold",    bus_if.Bus_oe[0], 1);
    bus_if.nOE[0] = 1'b1;
    bus_if.nME[0] = 1'b1;
    tick();
    chk("rd_oe_clear",   bus_if.Bus_oe[0], 0);

    // ---- write on ch2, ack after three request cycles
    bus_if.nALE[2] = 1'b0;
    set_bus(2, 64'h40);
    tick();
    bus_if.nALE[2] = 1'b1;
    set_bus(2, 64'h55AA);
    bus_if.nME[2]  = 1'b0;
    bus_if.RnW[2]  = 1'b0;
    tick();                                   // PEND, wdata captured
    set_bus(2, 64'hFFFF_FFFF);
    tick();                                   // grant
    chk("wr_req_c1",   bus_if.Mem_req,   1);
    chk("wr_we",       bus_if.Mem_we,    1);
    chk("wr_addr",     bus_if.Mem_addr,  64'h40);
    chk("wr_wdata_c1", bus_if.Mem_wdata, 64'h55AA);
    tick();
    chk("wr_req_c2",   bus_if.Mem_req,   1);
    chk("wr_wdata_c2", bus_if.Mem_wdata, 64'h55AA);
    tick();
    chk("wr_req_c3",   bus_if.Mem_req,   1);
    chk("wr_wdata_c3", bus_if.Mem_wdata, 64'h55AA);
    bus_if.Mem_ack = 1'b1;
    tick();                                   // ack edge: ch2 IDLE
    bus_if.Mem_ack = 1'b0;
    bus_if.nME[2]  = 1'b1;
    bus_if.RnW[2]  = 1'b1;
    chk("wr_req_drop", bus_if.Mem_req,  0);
    chk("wr_nwait2",   bus_if.nWait[2], 1);
    chk("wr_oe2",      bus_if.Bus_oe[2], 0);
    tick();
    chk("wr_oe2_after", bus_if.Bus_oe[2], 0);
    chk("wr_err",       bus_if.Err,       0);

    // ---- reset mid-transaction with an ack pending
    bus_if.nALE[1] = 1'b0;
    set_bus(1, 64'h77);
    tick();
    bus_if.nALE[1] = 1'b1;
    bus_if.nME[1]  = 1'b0;
    bus_if.nOE[1]  = 1'b0;
    tick();
    tick();                                   // grant ch1 (ptr=3 wraps to 1)
    chk("mr_req",  bus_if.Mem_req,  1);
    chk("mr_addr", bus_if.Mem_addr, 64'h77);
    bus_if.Mem_ack = 1'b1;
    #2;
    nReset = 1'b0;
    #1;
    chk("mr_req_drop", bus_if.Mem_req,  0);
    chk("mr_nwait",    bus_if.nWait,    4'hF);
    chk("mr_oe",       bus_if.Bus_oe,   0);
    chk("mr_addr0",    bus_if.Mem_addr, 0);
    chk("mr_bus_out0", bout(0),         0);
    bus_if.nME[1]  = 1'b1;
    bus_if.nOE[1]  = 1'b1;
    bus_if.Mem_ack = 1'b0;
    tick();
    chk("mr_req_hold", bus_if.Mem_req, 0);
    nReset = 1'b1;
    tick();

    // ---- contention: four reads PEND on the same edge
    bus_if.nALE = '0;
    for (int i = 0; i < NC; i++) set_bus(i, 64'(16 * (i + 1)));
    tick();
    bus_if.nALE = '1;
    bus_if.nME  = '0;
    bus_if.nOE  = '0;
    bus_if.RnW  = '1;
    tick();                                   // all PEND
    chk("ct_nwait_all", bus_if.nWait, 0);
    for (int k = 0; k < NC; k++) begin
      tick();                                 // grant k
      exp_addr = 64'(16 * (k + 1));
      chk("ct_req",  bus_if.Mem_req,  1);
      chk("ct_addr", bus_if.Mem_addr, exp_addr);
      exp_rd = 64'hC0DE_0000_0000_0000 | 64'(k);
      bus_if.Mem_ack   = 1'b1;
      bus_if.Mem_rdata = exp_rd;
      tick();                                 // ack edge
      bus_if.Mem_ack   = 1'b0;
      chk("ct_idle_gap", bus_if.Mem_req, 0);
      chk("ct_rdata",    bout(k),        exp_rd);
    end
    chk("ct_oe_all", bus_if.Bus_oe, 4'hF);
    bus_if.nME = '1;
    bus_if.nOE = '1;
    tick();                                   // all IDLE
    chk("ct_oe_none", bus_if.Bus_oe, 0);

    // ch1 goes PEND first, ch0 becomes PEND on ch1's grant edge
    bus_if.nALE[1] = 1'b0;
    set_bus(1, 64'h21);
    tick();
    bus_if.nALE[1] = 1'b1;
    bus_if.nME[1]  = 1'b0;
    bus_if.nOE[1]  = 1'b0;
    bus_if.nALE[0] = 1'b0;
    set_bus(0, 64'h11);
    tick();                                   // ch1 PEND, ch0 ADDR
    bus_if.nALE[0] = 1'b1;
    bus_if.nME[0]  = 1'b0;
    bus_if.nOE[0]  = 1'b0;
    tick();                                   // grant ch1, ch0 PEND
    chk("rr_first_addr", bus_if.Mem_addr, 64'h21);

    // ---- protocol error: nALE1 while ch1 BUSY
    bus_if.nALE[1] = 1'b0;
    set_bus(1, 64'h999);
    tick();
    bus_if.nALE[1] = 1'b1;
    chk("pe_err",       bus_if.Err,      4'b0010);
    chk("pe_addr_hold", bus_if.Mem_addr, 64'h21);
    chk("pe_req_hold",  bus_if.Mem_req,  1);
    bus_if.Mem_ack   = 1'b1;
    bus_if.Mem_rdata = 64'h1111;
    tick();
    bus_if.Mem_ack   = 1'b0;
    tick();                                   // grant ch0
    chk("rr_second_addr", bus_if.Mem_addr, 64'h11);
    bus_if.Mem_ack   = 1'b1;
    bus_if.Mem_rdata = 64'h0000;
    tick();
    bus_if.Mem_ack   = 1'b0;

    // ---- early release on ch3
    bus_if.nALE[3] = 1'b0;
    set_bus(3, 64'h300);
    tick();
    bus_if.nALE[3] = 1'b1;
    bus_if.nME[3]  = 1'b0;
    bus_if.nOE[3]  = 1'b0;
    tick();
    tick();                                   // grant ch3 (ptr=1, ch1 in DONE)
    chk("er_addr", bus_if.Mem_addr, 64'h300);
    bus_if.Mem_ack   = 1'b1;
    bus_if.Mem_rdata = 64'h3333;
    tick();
    bus_if.Mem_ack   = 1'b0;
    chk("er_oe_done", bus_if.Bus_oe, 4'b1011);
    bus_if.nALE[3] = 1'b0;
    set_bus(3, 64'h3A0);
    tick();                                   // DONE -> ADDR
    bus_if.nALE[3] = 1'b1;
    chk("er_oe_clear", bus_if.Bus_oe[3], 0);
    chk("er_nwait",    bus_if.nWait[3],  1);
    tick();                                   // PEND
    tick();                                   // grant with the new address
    chk("er_new_addr", bus_if.Mem_addr, 64'h3A0);
    bus_if.Mem_ack = 1'b1;
    tick();
    bus_if.Mem_ack = 1'b0;
    chk("err_sticky", bus_if.Err, 4'b0010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
